// File: rtl/gpio_pad_arbiter_pkg.sv
// Shared types and defaults for the GPIO pad-bank arbiter.
// Imported by the arbiter top and its round-robin picker.
package croc_pkg;

  localparam int NumReqDef     = 4;
  localparam int DeadCyclesDef = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    OWNED = 2'd2
  } pad_arb_state_e;

endpackage

// File: rtl/gpio_pad_arbiter_if.sv
// Requester-side bundle of the pad arbiter.
// master = requester side, slave = arbiter side.
interface gpio_pad_arbiter_if #(
  parameter int NumReq   = 4,
  parameter int PadCount = 32
);

  logic [NumReq-1:0]               req_i;
  logic [NumReq-1:0]               gnt_o;
  logic [NumReq-1:0][PadCount-1:0] req_gpio_o_i;
  logic [NumReq-1:0][PadCount-1:0] req_gpio_oe_i;
  logic [NumReq-1:0][PadCount-1:0] req_gpio_i_o;
  logic                            revoke_o;

  modport master (
    output req_i,
    output req_gpio_o_i,
    output req_gpio_oe_i,
    input  gnt_o,
    input  req_gpio_i_o,
    input  revoke_o
  );

  modport slave (
    input  req_i,
    input  req_gpio_o_i,
    input  req_gpio_oe_i,
    output gnt_o,
    output req_gpio_i_o,
    output revoke_o
  );

endinterface

// File: rtl/gpio_pad_arbiter_rr_pick.sv
// Round-robin picker: first set req bit scanning up from ptr,
// wrapping at NumReq.
module pad_arb_rr_pick
  import croc_pkg::*;
#(
  parameter int NumReq = NumReqDef,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   idx,
  output logic              valid
);

  int j;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < NumReq; i++) begin
      j = (int'(ptr) + i) % NumReq;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/gpio_pad_arbiter.sv
// Round-robin owner of one GPIO pad bank with tristate dead time.
// Define PAD_ARB_TIMEOUT_EN to enable forced revoke after TimeoutCycles.
module gpio_pad_arbiter
  import croc_pkg::*;
#(
  parameter int NumReq        = NumReqDef,
  parameter int PadCount      = 32,
  parameter int DeadCycles    = DeadCyclesDef,
  parameter int TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  gpio_pad_arbiter_if.slave   bus,
  output logic [PadCount-1:0] pad_gpio_o,
  output logic [PadCount-1:0] pad_gpio_oe_o,
  input  logic [PadCount-1:0] pad_gpio_i
);

  localparam int IdxW  = $clog2(NumReq);
  localparam int DeadW = (DeadCycles > 1) ? $clog2(DeadCycles) : 1;
  localparam logic [DeadW-1:0] DeadLoad = DeadW'(DeadCycles - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumReq - 1);

  if (NumReq < 2) begin : g_chk_req
    $error("NumReq must be at least 2");
  end
  if (DeadCycles < 1) begin : g_chk_dead
    $error("DeadCycles must be at least 1");
  end
  if (TimeoutCycles < 1) begin : g_chk_to
    $error("TimeoutCycles must be at least 1");
  end

  pad_arb_state_e   state_q, state_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  cand_q, cand_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DeadW-1:0] dead_q, dead_d;

  logic [NumReq-1:0] own_oh;
  logic [NumReq-1:0] pick_req;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;

`ifdef PAD_ARB_TIMEOUT_EN
  localparam int ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [ToW-1:0] ToMax = ToW'(TimeoutCycles - 1);

  logic [ToW-1:0] to_q, to_d;
  logic           revoke_q, revoke_d;
`endif

  // The current owner never competes for its own successor slot.
  always_comb begin
    own_oh = '0;
    if (state_q == OWNED) begin
      own_oh[owner_q] = 1'b1;
    end
    pick_req = bus.req_i & ~own_oh;
  end

  pad_arb_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cand_d   = cand_q;
    rr_ptr_d = rr_ptr_q;
    dead_d   = dead_q;
`ifdef PAD_ARB_TIMEOUT_EN
    to_d     = to_q;
    revoke_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          cand_d  = pick_idx;
          dead_d  = DeadLoad;
          state_d = DEAD;
        end
      end
      DEAD: begin
        if (dead_q == '0) begin
          if (bus.req_i[cand_q]) begin
            owner_d  = cand_q;
            rr_ptr_d = (cand_q == LastIdx) ? '0 : cand_q + 1'b1;
            state_d  = OWNED;
`ifdef PAD_ARB_TIMEOUT_EN
            to_d     = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          dead_d = dead_q - 1'b1;
        end
      end
      OWNED: begin
        if (!bus.req_i[owner_q]) begin
          if (pick_valid) begin
            cand_d  = pick_idx;
            dead_d  = DeadLoad;
            state_d = DEAD;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef PAD_ARB_TIMEOUT_EN
        // Saturated counter only revokes once someone else is waiting.
        else if (to_q == ToMax) begin
          if (pick_valid) begin
            cand_d   = pick_idx;
            dead_d   = DeadLoad;
            state_d  = DEAD;
            revoke_d = 1'b1;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      cand_q   <= '0;
      rr_ptr_q <= '0;
      dead_q   <= '0;
`ifdef PAD_ARB_TIMEOUT_EN
      to_q     <= '0;
      revoke_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cand_q   <= cand_d;
      rr_ptr_q <= rr_ptr_d;
      dead_q   <= dead_d;
`ifdef PAD_ARB_TIMEOUT_EN
      to_q     <= to_d;
      revoke_q <= revoke_d;
`endif
    end
  end

  // Outputs decode from state only, so reset tristates immediately.
  always_comb begin
    bus.gnt_o        = '0;
    bus.req_gpio_i_o = '0;
    pad_gpio_o       = '0;
    pad_gpio_oe_o    = '0;
    if (state_q == OWNED) begin
      bus.gnt_o[owner_q]        = 1'b1;
      bus.req_gpio_i_o[owner_q] = pad_gpio_i;
      pad_gpio_o                = bus.req_gpio_o_i[owner_q];
      pad_gpio_oe_o             = bus.req_gpio_oe_i[owner_q];
    end
  end

`ifdef PAD_ARB_TIMEOUT_EN
  assign bus.revoke_o = revoke_q;
`else
  assign bus.revoke_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_pad_arbiter.sv
// Bench for gpio_pad_arbiter: cycle model plus directed scenarios.
// Timeout scenarios run when PAD_ARB_TIMEOUT_EN is defined.
module tb_gpio_pad_arbiter;

  localparam int N  = 4;
  localparam int P  = 32;
  localparam int DC = 2;
`ifdef PAD_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [P-1:0] pad_o;
  logic [P-1:0] pad_oe;
  logic [P-1:0] pad_i;

  int checks = 0;
  int fails  = 0;

  gpio_pad_arbiter_if #(.NumReq(N), .PadCount(P)) bus ();

  gpio_pad_arbiter #(
    .NumReq        (N),
    .PadCount      (P),
    .DeadCycles    (DC),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .pad_gpio_o    (pad_o),
    .pad_gpio_oe_o (pad_oe),
    .pad_gpio_i    (pad_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int start, int excl);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (start + i) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  // Behavioural model: owner/candidate indices and grant due times.
  int m_owner = -1;
  int m_cand  = -1;
  int m_gat   = 0;
  int m_rr    = 0;
  int m_since = 0;
  bit m_rev   = 1'b0;
  int cyc     = 0;

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      m_owner = -1;
      m_cand  = -1;
      m_rr    = 0;
      m_rev   = 1'b0;
    end else begin
      m_rev = 1'b0;
      if (m_owner >= 0) begin
        if (!bus.req_i[m_owner]) begin
          nxt     = pick(bus.req_i, m_rr, m_owner);
          m_owner = -1;
          if (nxt >= 0) begin
            m_cand = nxt;
            m_gat  = cyc + DC;
          end
        end
`ifdef PAD_ARB_TIMEOUT_EN
        else if (cyc - m_since >= TO) begin
          nxt = pick(bus.req_i, m_rr, m_owner);
          if (nxt >= 0) begin
            m_owner = -1;
            m_rev   = 1'b1;
            m_cand  = nxt;
            m_gat   = cyc + DC;
          end
        end
`endif
      end else if (m_cand >= 0) begin
        if (cyc == m_gat) begin
          if (bus.req_i[m_cand]) begin
            m_owner = m_cand;
            m_rr    = (m_cand + 1) % N;
            m_since = cyc;
          end
          m_cand = -1;
        end
      end else begin
        nxt = pick(bus.req_i, m_rr, -1);
        if (nxt >= 0) begin
          m_cand = nxt;
          m_gat  = cyc + DC;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [N-1:0]      e_gnt;
    logic [P-1:0]      e_o;
    logic [P-1:0]      e_oe;
    logic [N*P-1:0]    e_in;
    if (!rst) begin
      e_gnt = '0;
      e_o   = '0;
      e_oe  = '0;
      e_in  = '0;
      if (m_owner >= 0) begin
        e_gnt[m_owner]      = 1'b1;
        e_o                 = bus.req_gpio_o_i[m_owner];
        e_oe                = bus.req_gpio_oe_i[m_owner];
        e_in[m_owner*P +: P] = pad_i;
      end
      chk("m_gnt", 128'(bus.gnt_o), 128'(e_gnt));
      chk("m_pad_o", 128'(pad_o), 128'(e_o));
      chk("m_pad_oe", 128'(pad_oe), 128'(e_oe));
      chk("m_gpio_in", 128'(bus.req_gpio_i_o), 128'(e_in));
      chk("m_revoke", 128'(bus.revoke_o), 128'(m_rev));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int z);
    z = 0;
    while (bus.gnt_o == '0 && z < 30) begin
      z++;
      tick();
    end
    if (bus.gnt_o == '0) begin
      checks++;
      fails++;
      $display("FAIL wait_gnt act=0 exp=nonzero");
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.req_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int oh_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int z;
    int n;
    int idx;
    int order[$];
    int exp_order[5];

    exp_order = '{0, 1, 2, 3, 0};
    bus.req_i = '0;
    for (int r = 0; r < N; r++) begin
      bus.req_gpio_o_i[r]  = 32'h1111_1111 * (r + 1);
      bus.req_gpio_oe_i[r] = 32'hFFFF_0000 | (r + 1);
    end
    pad_i = 32'hA5A5_A5A5;
    tick();
    tick();
    chk("rst_gnt", 128'(bus.gnt_o), 128'h0);
    chk("rst_pad_o", 128'(pad_o), 128'h0);
    chk("rst_pad_oe", 128'(pad_oe), 128'h0);
    chk("rst_gpio_in", 128'(bus.req_gpio_i_o), 128'h0);
    chk("rst_revoke", 128'(bus.revoke_o), 128'h0);
    rst = 1'b0;

    // single requester latency
    bus.req_i = 4'b0001;
    tick();
    chk("t1_gnt_e0", 128'(bus.gnt_o), 128'h0);
    chk("t1_oe_e0", 128'(pad_oe), 128'h0);
    tick();
    chk("t1_gnt_e1", 128'(bus.gnt_o), 128'h0);
    chk("t1_oe_e1", 128'(pad_oe), 128'h0);
    tick();
    chk("t1_gnt_e2", 128'(bus.gnt_o), 128'h1);
    chk("t1_pad_o", 128'(pad_o), 128'h1111_1111);
    chk("t1_pad_oe", 128'(pad_oe), 128'hFFFF_0001);
    bus.req_i = '0;
    tick();
    chk("t1_rel", 128'(bus.gnt_o), 128'h0);
    repeat (3) tick();

    // round robin with 3-cycle ownerships
    do_reset();
    bus.req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(z);
      if (k > 0) chk("rr_dead", 128'(z), 128'(DC));
      idx = oh_idx(bus.gnt_o);
      order.push_back(idx);
      tick();
      tick();
      if (idx >= 0) bus.req_i[idx] = 1'b0;
      tick();
      chk("rr_drop", 128'(bus.gnt_o), 128'h0);
      if (idx >= 0) bus.req_i[idx] = 1'b1;
    end
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_order%0d", k), 128'(order[k]), 128'(exp_order[k]));
    bus.req_i = '0;
    repeat (6) tick();

    // withdraw during dead time
    bus.req_i = 4'b0010;
    tick();
    bus.req_i = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("wd_gnt", 128'(bus.gnt_o), 128'h0);
    end

    // input masking with owner 2
    bus.req_i = 4'b0100;
    wait_gnt(z);
    chk("im_gnt", 128'(bus.gnt_o), 128'h4);
    chk("im_row2", 128'(bus.req_gpio_i_o[2]), 128'hA5A5_A5A5);
    chk("im_rest", 128'(bus.req_gpio_i_o) & ~(128'hFFFF_FFFF << 64),
        128'h0);
    pad_i = 32'h3C3C_0FF0;
    #1;
    chk("im_comb", 128'(bus.req_gpio_i_o[2]), 128'h3C3C_0FF0);
    bus.req_i = '0;
    repeat (3) tick();
    pad_i = 32'hA5A5_A5A5;

    // async reset mid-ownership
    bus.req_i = 4'b0001;
    wait_gnt(z);
    chk("ar_pre_oe", 128'(pad_oe), 128'hFFFF_0001);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_oe", 128'(pad_oe), 128'h0);
    chk("ar_gnt", 128'(bus.gnt_o), 128'h0);
    chk("ar_pad_o", 128'(pad_o), 128'h0);
    bus.req_i = 4'b1010;
    tick();
    tick();
    rst = 1'b0;
    wait_gnt(z);
    chk("ar_first", 128'(bus.gnt_o), 128'h2);
    bus.req_i = '0;
    repeat (3) tick();

`ifdef PAD_ARB_TIMEOUT_EN
    do_reset();
    bus.req_i = 4'b0011;
    wait_gnt(z);
    chk("to_gnt0", 128'(bus.gnt_o), 128'h1);
    n = 0;
    while (!bus.revoke_o && n < 30) begin
      tick();
      n++;
    end
    chk("to_cycles", 128'(n), 128'(TO));
    chk("to_gnt_drop", 128'(bus.gnt_o), 128'h0);
    tick();
    chk("to_pulse", 128'(bus.revoke_o), 128'h0);
    tick();
    chk("to_gnt1", 128'(bus.gnt_o), 128'h2);
    bus.req_i = '0;
    repeat (4) tick();

    do_reset();
    bus.req_i = 4'b0001;
    wait_gnt(z);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("ns_revoke", 128'(bus.revoke_o), 128'h0);
      chk("ns_gnt", 128'(bus.gnt_o), 128'h1);
    end
    bus.req_i = '0;
    repeat (3) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

endmodule
